// File: rtl/one_counter_arbiter.sv
// one_counter_arbiter: round-robin front end for one shared ones-counter engine.
// It takes one requester's operand, starts the external engine, waits for done
// or a timeout, and returns the count to the requester that won.
//
// Handshake summary:
//   requester -> arbiter: i_req[k] is a level. Hold it and i_data slot k until
//     o_gnt[k] pulses. After the grant, keep i_req[k] low until o_res_valid[k].
//   arbiter -> engine: o_eng_start pulses once and o_eng_data is stable from
//     START until WAIT ends. i_eng_done/i_eng_count are looked at only in WAIT.
//   arbiter -> requester: o_res_valid[k] pulses once. o_res and o_err are valid
//     in that cycle and keep their values until the next report.
module one_counter_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_data,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_res_valid,
    output logic [WIDTH-1:0]      o_res,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_eng_start,
    output logic [WIDTH-1:0]      o_eng_data,
    input  logic                  i_eng_done,
    input  logic [WIDTH-1:0]      i_eng_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  timer_inc;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  eng_data_q, eng_data_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   res_valid_q, res_valid_d;
    logic              eng_start_q, eng_start_d;
    logic              busy_q, busy_d;

    logic [PTR_W-1:0]  rr_win;
    logic              rr_found;

    // Requester index at offset 'off' past pointer 'p', wrapped modulo NREQ.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin pick: scan from the requester just after the last one served.
    always_comb begin
        rr_win   = ptr_q;
        rr_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!rr_found && i_req[rr_index(ptr_q, i)]) begin
                rr_found = 1'b1;
                rr_win   = rr_index(ptr_q, i);
            end
        end
    end

    // Next-state and registered-output logic. The pulse outputs are computed one
    // cycle early so that each one is high for the whole cycle of its state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        timer_d     = timer_q;
        res_d       = res_q;
        err_d       = err_q;
        eng_data_d  = eng_data_q;
        gnt_d       = '0;
        res_valid_d = '0;
        eng_start_d = 1'b0;
        timer_inc   = timer_q + TMR_W'(1);

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    win_d       = rr_win;
                    eng_data_d  = i_data[rr_win*WIDTH +: WIDTH];
                    gnt_d       = ONE_HOT0 << rr_win;
                    eng_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // If done and the timeout land in the same cycle, done wins.
                if (i_eng_done) begin
                    res_d       = i_eng_count;
                    err_d       = 1'b0;
                    res_valid_d = ONE_HOT0 << win_q;
                    state_d     = REPORT;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMR_W'(TIMEOUT)) begin
                        res_d       = '0;
                        err_d       = 1'b1;
                        res_valid_d = ONE_HOT0 << win_q;
                        state_d     = REPORT;
                    end
                end
            end
            REPORT: begin
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset discards any operation in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NREQ - 1);
            win_q       <= '0;
            timer_q     <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            eng_data_q  <= '0;
            gnt_q       <= '0;
            res_valid_q <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            timer_q     <= timer_d;
            res_q       <= res_d;
            err_q       <= err_d;
            eng_data_q  <= eng_data_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_res_valid = res_valid_q;
    assign o_res       = res_q;
    assign o_err       = err_q;
    assign o_busy      = busy_q;
    assign o_eng_start = eng_start_q;
    assign o_eng_data  = eng_data_q;

endmodule

// File: tb/tb_one_counter_arbiter.sv
// Testbench for one_counter_arbiter: requesters, an engine model and a
// transaction-level reference with an expected-result queue.
module tb_one_counter_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;
  localparam int EXP_W   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_count;
  logic [NREQ-1:0]       gnt, res_valid;
  logic [WIDTH-1:0]      res, eng_data;
  logic                  err, busy, eng_start;

  one_counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_(rst_n), .i_req(req), .i_data(data),
    .o_gnt(gnt), .o_res_valid(res_valid), .o_res(res), .o_err(err),
    .o_busy(busy), .o_eng_start(eng_start), .o_eng_data(eng_data),
    .i_eng_done(eng_done), .i_eng_count(eng_count)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EXP_W-1:0] exp_q[$];     // {cycle[63:32], winner[31:24], err[23:16], res[15:0]}
  int               gnt_log[$];

  logic [NREQ-1:0]  pend     = '0;  // requests currently raised
  logic [NREQ-1:0]  inflight = '0;  // granted, result not yet delivered
  logic [WIDTH-1:0] opnd[NREQ];
  int               ptr_m    = NREQ - 1;
  int               lat_cfg  = 2;   // 0: random 1..TIMEOUT+2, NEVER: no done
  int               eng_wait = -1;
  int               eng_val  = 0;
  logic             op_active = 1'b0;
  logic             cool      = 1'b0;
  logic             inject_done = 1'b0;
  logic [WIDTH-1:0] exp_data  = '0;
  logic [WIDTH-1:0] last_res  = '0;
  logic             last_err  = 1'b0;
  logic [WIDTH-1:0] rep_res   = '0;
  logic             rep_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the last one served.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    req = pend;
    for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = opnd[k];
  endtask

  task automatic raise(input int k, input logic [WIDTH-1:0] v);
    opnd[k] = v;
    pend[k] = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    pend = '0;
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((pend != 0 || inflight != 0 || op_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'(1));
  endtask

  // ---------------- reference model, engine model and scoreboard ----------------
  initial begin
    logic             rst_seen;
    logic [EXP_W-1:0] e;
    int               w;
    int               lat;
    forever begin
      @(posedge clk);
      rst_seen = rst_n;
      #1;
      cyc++;
      if (!rst_seen) begin
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res", 64'(res), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_eng_start", 64'(eng_start), 64'(0));
        check("rst_eng_data", 64'(eng_data), 64'(0));
        ptr_m = NREQ - 1; op_active = 1'b0; cool = 1'b0; inflight = '0;
        exp_q.delete(); eng_wait = -1; eng_done = 1'b0;
        last_res = '0; last_err = 1'b0; inject_done = 1'b0;
      end else begin
        // engine: done lands in the lat-th cycle after the start pulse
        eng_done  = 1'b0;
        eng_count = WIDTH'($urandom);
        if (inject_done) begin
          eng_done = 1'b1;
          inject_done = 1'b0;
        end
        if (eng_wait > 0) begin
          eng_wait--;
          if (eng_wait == 0) begin
            eng_done  = 1'b1;
            eng_count = WIDTH'(eng_val);
            eng_wait  = -1;
          end
        end
        // grant: a request seen while the arbiter is free is granted one cycle later
        if (!op_active && !cool && req != 0) begin
          w = pick(req, ptr_m);
          check("gnt", 64'(gnt), 64'(1) << w);
          check("eng_start", 64'(eng_start), 64'(1));
          check("eng_data", 64'(eng_data), 64'(opnd[w]));
          gnt_log.push_back(w);
          lat = (lat_cfg == 0) ? $urandom_range(1, TIMEOUT + 2) : lat_cfg;
          eng_wait = (lat_cfg == NEVER) ? -1 : lat;
          eng_val  = $countones(opnd[w]);
          exp_data = opnd[w];
          if (lat <= TIMEOUT)
            exp_q.push_back({32'(cyc + lat + 1), 8'(w), 8'(0), WIDTH'(eng_val)});
          else
            exp_q.push_back({32'(cyc + TIMEOUT + 1), 8'(w), 8'(1), WIDTH'(0)});
          op_active   = 1'b1;
          inflight[w] = 1'b1;
          pend[w]     = 1'b0;
          opnd[w]     = WIDTH'($urandom);  // data may change after the grant
          drive();
        end else begin
          check("gnt_quiet", 64'(gnt), 64'(0));
          check("eng_start_quiet", 64'(eng_start), 64'(0));
          if (op_active && !(exp_q.size() > 0 && exp_q[0][63:32] == 32'(cyc)))
            check("eng_data_hold", 64'(eng_data), 64'(exp_data));
        end
        cool = 1'b0;
        check("busy", 64'(busy), 64'(op_active));
        // result
        if (exp_q.size() > 0 && exp_q[0][63:32] == 32'(cyc)) begin
          e = exp_q.pop_front();
          w = int'(e[31:24]);
          check("res_valid", 64'(res_valid), 64'(1) << w);
          check("res", 64'(res), 64'(e[15:0]));
          check("err", 64'(err), 64'(e[16]));
          rep_res = res; rep_err = err;
          last_res = e[15:0]; last_err = e[16];
          ptr_m = w; inflight[w] = 1'b0; op_active = 1'b0; cool = 1'b1;
        end else begin
          check("res_valid_quiet", 64'(res_valid), 64'(0));
          check("res_hold", 64'(res), 64'(last_res));
          check("err_hold", 64'(err), 64'(last_err));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [WIDTH-1:0] fd[NREQ];
    rst_n = 1'b0; req = '0; data = '0; eng_done = 1'b0; eng_count = '0;
    for (int k = 0; k < NREQ; k++) opnd[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single request
    lat_cfg = 3; gnt_log.delete();
    raise(0, 16'hF0F0);
    wait_drain(50);
    check("single_gnt_count", 64'(gnt_log.size()), 64'(1));
    check("single_res", 64'(rep_res), 64'(8));
    check("single_err", 64'(rep_err), 64'(0));

    // round-robin fairness with all requesters kept active
    do_reset();
    lat_cfg = 2; gnt_log.delete();
    fd[0] = 16'h0001; fd[1] = 16'h0003; fd[2] = 16'h0007; fd[3] = 16'h000F;
    n = 0;
    while (gnt_log.size() < 5 && n < 200) begin
      for (int k = 0; k < NREQ; k++)
        if (!pend[k] && !inflight[k] && gnt_log.size() < 5) raise(k, fd[k]);
      @(negedge clk);
      n++;
    end
    wait_drain(300);
    check("fair_count", 64'(gnt_log.size() >= 5), 64'(1));
    check("fair_0", 64'(gnt_log[0]), 64'(0));
    check("fair_1", 64'(gnt_log[1]), 64'(1));
    check("fair_2", 64'(gnt_log[2]), 64'(2));
    check("fair_3", 64'(gnt_log[3]), 64'(3));
    check("fair_4", 64'(gnt_log[4]), 64'(0));

    // pointer rotation after serving requester 2
    do_reset();
    lat_cfg = 1;
    raise(2, 16'h00FF);
    wait_drain(50);
    gnt_log.delete();
    raise(1, 16'h0101);
    raise(3, 16'h7000);
    wait_drain(100);
    check("rot_count", 64'(gnt_log.size()), 64'(2));
    check("rot_first", 64'(gnt_log[0]), 64'(3));
    check("rot_second", 64'(gnt_log[1]), 64'(1));

    // timeout, late done in IDLE, then a normal operation
    lat_cfg = NEVER;
    raise(1, 16'h1234);
    wait_drain(50);
    check("to_err", 64'(rep_err), 64'(1));
    check("to_res", 64'(rep_res), 64'(0));
    inject_done = 1'b1;
    repeat (4) @(negedge clk);
    lat_cfg = 1;
    raise(1, 16'h000F);
    wait_drain(50);
    check("to_next_res", 64'(rep_res), 64'(4));
    check("to_next_err", 64'(rep_err), 64'(0));

    // done on the last allowed WAIT cycle
    lat_cfg = TIMEOUT;
    raise(2, 16'hFFFF);
    wait_drain(50);
    check("bnd_res", 64'(rep_res), 64'(16));
    check("bnd_err", 64'(rep_err), 64'(0));

    // reset in the middle of WAIT
    lat_cfg = NEVER;
    raise(3, 16'hAAAA);
    n = 0;
    while (!op_active && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_started", 64'(op_active), 64'(1));
    repeat (3) @(negedge clk);
    do_reset();
    repeat (12) @(negedge clk);
    gnt_log.delete();
    lat_cfg = 1;
    for (int k = 0; k < NREQ; k++) raise(k, WIDTH'(k * 16'h1111));
    n = 0;
    while (gnt_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_gnt_seen", 64'(gnt_log.size()), 64'(1));
    check("mid_first", 64'(gnt_log[0]), 64'(0));
    wait_drain(200);

    // randomized traffic, including timeouts and late dones
    lat_cfg = 0;
    repeat (800) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && !inflight[k] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       raise(k, 16'h0000);
            1:       raise(k, 16'hFFFF);
            default: raise(k, WIDTH'($urandom));
          endcase
        end
      end
    end
    wait_drain(400);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_counter_arbiter.md
# one_counter_arbiter

Round-robin scheduler that shares one ones-counter engine between NREQ requesters. It captures a requester's operand, starts the engine, waits for completion with a timeout guard, and returns the count to the winning requester. It sits between client blocks and a single shared ones-counter datapath, which is instantiated outside this block.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, operand and count width
- TIMEOUT, 64, maximum WAIT cycles before abort (≥1)

- i_clk  in  1  clock; all logic on posedge
- i_rst_  in  1  reset; one clock; reset is synchronous and active-low
- i_req  in  NREQ  per-requester request level
- i_data  in  NREQ*WIDTH  operand k at [k*WIDTH +: WIDTH]
- o_gnt  out  NREQ  one-hot grant pulse, 1 cycle, marks operand captured
- o_res_valid  out  NREQ  one-hot result pulse, 1 cycle
- o_res  out  WIDTH  count result, valid with o_res_valid
- o_err  out  1  timeout flag, valid with o_res_valid
- o_busy  out  1  high whenever state ≠ IDLE
- o_eng_start  out  1  one-cycle engine start pulse
- o_eng_data  out  WIDTH  operand to engine, held from START until leaving WAIT
- i_eng_done  in  1  engine completion, sampled only in WAIT
- i_eng_count  in  WIDTH  engine result, sampled when i_eng_done is sampled high

## Operation
- **States:** IDLE, START, WAIT, REPORT (registered, binary encoded).
- **IDLE:**
  - If i_req ≠ 0, select winner w by round-robin. Priority order is ptr+1, ptr+2, … modulo NREQ, where ptr is the last served requester.
  - Register w, and capture i_data slot w into o_eng_data.
  - Next state is START.
  - If i_req = 0, stay in IDLE.
- **START:** o_gnt[w]=1 and o_eng_start=1 for this one cycle. Clear the timer. Next state is WAIT, unconditionally.
- **WAIT:**
  - If i_eng_done=1, register i_eng_count into o_res, set o_err=0, and go to REPORT.
  - Otherwise increment the timer. If the timer reaches TIMEOUT, set o_res=0, set o_err=1, and go to REPORT.
  - If done arrives in the same cycle that the timeout would fire, done wins.
- **REPORT:** o_res_valid[w]=1 for one cycle. Set ptr to w. Next state is IDLE.
- **Timer:** width is clog2(TIMEOUT+1). At most TIMEOUT WAIT cycles are spent per operation.
- **Requester handshake:**
  - The requester holds i_req and i_data until it sees o_gnt.
  - After o_gnt, i_data may change.
  - The requester holds i_req low until its o_res_valid; a high i_req after o_res_valid is a new request.
  - A request dropped before it is sampled in IDLE is never granted. A request sampled in IDLE is committed.
- **Engine protocol:**
  - i_eng_done during IDLE, START or REPORT is ignored. This includes a late done from an aborted operation.
  - The engine must not be restarted before REPORT.
- **Zero operand:** not special-cased; the result is whatever i_eng_count returns.
- **o_res and o_err** hold their values until the next REPORT.
- **Reset (i_rst_=0 at a posedge), including mid-operation:**
  - State goes to IDLE, and ptr goes to NREQ-1, so requester 0 has first priority.
  - The timer, o_res, o_err and o_eng_data go to 0.
  - o_gnt, o_res_valid, o_eng_start and o_busy go to 0.
  - Any in-flight result is discarded, and no res_valid is issued for it.

## Timing
- Request sampled in IDLE at cycle T:
  - T+1 is START: o_gnt and o_eng_start are high.
  - T+2 is the first WAIT cycle.
- Engine done at cycle D (a WAIT cycle) → REPORT at D+1 → IDLE at D+2.
- Minimum turnaround, request sampled to o_res_valid, is 3 cycles (done in the first WAIT cycle).
- Back-to-back throughput is one operation per 4 cycles minimum: IDLE, START, WAIT, REPORT.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Single request.** Stimulus: reset, then i_req=0001, data0=16'hF0F0, with an engine model whose done comes 3 cycles after start. Required response:
  - o_gnt=0001 and o_eng_start at T+1.
  - o_res_valid=0001 with o_res=8, o_err=0 at T+5.
  - o_busy low at T+6.
- **Round-robin fairness.** Stimulus: all four requesters active continuously, data 0x0001, 0x0003, 0x0007, 0x000F. Required response: grants in order 0,1,2,3,0, with results 1,2,3,4 delivered to the matching o_res_valid bit.
- **Pointer rotation.** Stimulus: after serving requester 2, raise requesters 1 and 3 together. Required response: 3 is granted first, then 1.
- **Timeout.** Stimulus: TIMEOUT=8, engine never signals done. Required response:
  - REPORT after exactly 8 WAIT cycles, with o_err=1 and o_res=0.
  - A done injected later, during IDLE, is ignored.
  - The next request completes normally.
- **Boundary done.** Stimulus: TIMEOUT=8, done on the 8th WAIT cycle, count 16'h0010 (operand 16'hFFFF). Required response: success with o_res=16 and o_err=0.
- **Reset mid-WAIT.** Stimulus: i_rst_=0 during WAIT. Required response:
  - On the next cycle, all outputs are 0 and o_busy=0.
  - No o_res_valid is issued.
  - A subsequent i_req=1111 is granted to requester 0 first.
